// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory for the MIPS core: a load or store commits LATENCY wait
// cycles after it is accepted, and stall holds the datapath until it has committed.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        err,
    output logic [31:0] out1,
    output logic [31:0] out2
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [31:0]     read_data_q;
    logic [31:0]     mem_q [DEPTH_WORDS];
    logic            commit_c;
    logic            req_c;
    logic            legal_c;
    logic            unused_adr_c;

    assign req_c        = mem_read | mem_write;
    assign legal_c      = (mem_read ^ mem_write) && (adr[1:0] == 2'b00);
    // Address bits above the word index wrap and are deliberately ignored.
    assign unused_adr_c = ^adr[31:AW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        err_d    = 1'b0;
        commit_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    if (legal_c) begin
                        idx_d   = adr[AW+1:2];
                        wdata_d = write_data;
                        we_d    = mem_write;
                        cnt_d   = CW'(LATENCY - 1);
                        state_d = S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    commit_c = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage and load result only change on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit_c) begin
            if (we_q) begin
                mem_q[idx_q] <= wdata_q;
            end else begin
                read_data_q <= mem_q[idx_q];
            end
        end
    end

    assign stall     = ((state_q == S_IDLE) && legal_c) || (state_q == S_WAIT);
    assign read_data = read_data_q;
    assign err       = err_q;
    assign out1      = mem_q[0];
    assign out2      = mem_q[1];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed test-plan steps followed by
// random traffic, all checked against an array model of the memory.
module tb_data_mem_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] adr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        err;
    logic [31:0] out1;
    logic [31:0] out2;

    logic [31:0] mdl [DEPTH];
    logic [31:0] mdl_rd;
    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .adr(adr), .write_data(write_data), .read_data(read_data),
        .stall(stall), .err(err), .out1(out1), .out2(out2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
        mdl_rd = '0;
    endtask

    // One legal access; returns at the negedge of its DONE cycle with strobes still held.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit chg);
        int n;
        int unsigned idx;
        idx = (a >> 2) % DEPTH;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; adr = a; write_data = d;
        n = 0;
        @(negedge clk);
        while (stall && n < 20) begin
            n++;
            if (chg && n == 2) begin
                adr = 32'h8;
                write_data = 32'hFFFF_FFFF;
            end
            @(negedge clk);
        end
        if (wr) mdl[idx] = d;
        else    mdl_rd = mdl[idx];
        chk("stall_cycles", 32'(n), 32'(LAT + 1));
        chk("read_data", read_data, mdl_rd);
        chk("out1", out1, mdl[0]);
        chk("out2", out2, mdl[1]);
        chk("err_legal", 32'(err), 32'd0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("stall_idle", 32'(stall), 32'd0);
    endtask

    task automatic illegal(input logic rd, input logic wr, input logic [31:0] a);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; adr = a; write_data = $urandom;
        @(negedge clk);
        chk("ill_stall", 32'(stall), 32'd0);
        chk("ill_err_early", 32'(err), 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("ill_err_pulse", 32'(err), 32'd1);
        chk("ill_read_data", read_data, mdl_rd);
        @(negedge clk);
        chk("ill_err_end", 32'(err), 32'd0);
        chk("ill_out1", out1, mdl[0]);
        chk("ill_out2", out2, mdl[1]);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; adr = '0; write_data = '0;
        model_reset();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out1", out1, 32'd0);
        chk("rst_out2", out2, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Store then load word 0.
        access(1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("load_word0", read_data, 32'h1234_5678);

        // Reset in WAIT of a store to word 1 discards it.
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; adr = 32'h4; write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mid_stall_pre", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; mem_write = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_read_data", read_data, 32'd0);
        chk("mid_rst_out1", out1, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out2", out2, 32'd0);
        access(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);

        // Wrap-around: 0x400 maps onto word 0.
        access(1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5, 1'b0);
        chk("wrap_out1", out1, 32'hA5A5_A5A5);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Illegal requests, then confirm word 2 untouched.
        illegal(1'b1, 1'b0, 32'h6);
        illegal(1'b1, 1'b1, 32'h8);
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

        // Address/data changed during WAIT must be ignored.
        access(1'b0, 1'b1, 32'h4, 32'hCAFE_F00D, 1'b1);
        chk("chg_out2", out2, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        idle();

        // Back-to-back alternating store/load with no idle gap.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) access(1'b0, 1'b1, 32'((i % 4) * 4), $urandom, 1'b0);
            else            access(1'b1, 1'b0, 32'(((i - 1) % 4) * 4), 32'h0, 1'b0);
        end
        idle();

        // Random traffic over the low words with random upper address bits.
        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7) << 2);
            if (op == 0)      illegal(1'b1, 1'b0, a | 32'($urandom_range(1, 3)));
            else if (op == 1) illegal(1'b1, 1'b1, a);
            else if (op == 2) idle();
            else if (op < 6)  access(1'b1, 1'b0, a, 32'h0, 1'b0);
            else              access(1'b0, 1'b1, a, $urandom, 1'b0);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
